// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// FSM state encoding and counter width helper.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    int r;
    r = $clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Half-adder cell and the full-adder bit built from two of them.
// The serial datapath uses one full_adder_bit per bit slot.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s1),
    .cout (c1)
  );

  half_adder u_ha1 (
    .a    (s1),
    .b    (cin),
    .sum  (sum),
    .cout (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder, one bit per clock.
// Valid/ready on both sides; result held in DONE until taken.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sum_sr;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            fa_s;
  logic            fa_c;

  full_adder_bit u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign in_ready = (state == S_IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sa        <= '0;
      sb        <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_ADD;
            busy  <= 1'b1;
          end
        end
        S_ADD: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sum_sr <= (sum_sr >> 1)
                  | (WIDTH'(fa_s) << (WIDTH - 1));
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle latches the result; later ones wait for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
            sum       <= sum_sr;
            cout      <= carry;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized check of bit_serial_adder against plain integer addition.
// Two instances: WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;

  logic       in_valid8, in_ready8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       out_valid8, out_ready8, cout8, busy8;

  logic       in_valid1, in_ready1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       out_valid1, out_ready1, cout1, busy1;

  int total;
  int bad;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  bit_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input int hold);
    int k;
    logic [8:0] e;
    e = 9'(ta) + 9'(tb) + 9'(tc);
    k = 0;
    while (!in_ready8 && k < 50) begin tick(); k++; end
    chk("rdy8", in_ready8, 1);
    a8 = ta; b8 = tb; cin8 = tc;
    in_valid8 = 1'b1;
    out_ready8 = (hold == 0);
    tick();
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 40) begin tick(); k++; end
    chk("lat8", k, 9);
    chk("sum8", sum8, e[7:0]);
    chk("cout8", cout8, e[8]);
    chk("busy8", busy8, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid8 = h[0];
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();
      chk("hold_v", out_valid8, 1);
      chk("hold_s", sum8, e[7:0]);
      chk("hold_c", cout8, e[8]);
      chk("hold_rdy", in_ready8, 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    chk("drop8", out_valid8, 0);
    chk("idle8", in_ready8, 1);
    chk("nbusy8", busy8, 0);
  endtask

  task automatic run1(input logic ta, input logic tb, input logic tc);
    int k;
    logic [1:0] e;
    e = 2'(ta) + 2'(tb) + 2'(tc);
    k = 0;
    while (!in_ready1 && k < 50) begin tick(); k++; end
    a1 = ta; b1 = tb; cin1 = tc;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    k = 0;
    while (!out_valid1 && k < 20) begin tick(); k++; end
    chk("lat1", k, 2);
    chk("sum1", sum1, e[0]);
    chk("cout1", cout1, e[1]);
    tick();
    chk("drop1", out_valid1, 0);
  endtask

  initial begin
    int k;
    int seen;
    logic [8:0] e;
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; out_ready8 = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; out_ready1 = 1;
    tick();
    in_valid8 = 1'b1;
    tick();
    chk("rst_rdy", in_ready8, 0);
    chk("rst_v", out_valid8, 0);
    chk("rst_s", sum8, 0);
    chk("rst_c", cout8, 0);
    chk("rst_b", busy8, 0);
    in_valid8 = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rdy1", in_ready8, 1);
    chk("rst_v1", out_valid1, 0);

    run8(8'h05, 8'h03, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b0, 0);
    run8(8'hFF, 8'hFF, 1'b1, 0);
    run8(8'hA5, 8'h3C, 1'b1, 5);

    // abort mid-ADD
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("ab_v", out_valid8, 0);
    chk("ab_b", busy8, 0);
    rst = 1'b0;
    #1;
    chk("ab_rdy", in_ready8, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) seen++;
    end
    chk("ab_none", seen, 0);

    // operands offered during ADD are not sampled
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    in_valid8 = 1'b1;
    tick();
    a8 = 8'h10; b8 = 8'h10;
    tick();
    tick();
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 40) begin tick(); k++; end
    chk("ig_s", sum8, 8'h02);
    chk("ig_c", cout8, 0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid8) seen++;
    end
    chk("ig_none", seen, 0);

    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), (i % 4 == 3) ? 2 : 0);

    run1(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      run1(1'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
